pc_unit: RTL and testbench

Program counter register and sequencer for the 9-bit CPU. Consumes the signed 8-bit jump value produced by the PC lookup table and the control strobes from the decoder, and advances, branches, or halts the PC each cycle. Its `pc` output drives instruction ROM addressing. An optional return-address stack supports call/return.

---
 rtl/pc_unit.sv | 175 +++++++++++++++++
 tb/tb_pc_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter register and IDLE/RUN/HALT sequencer; drives instruction ROM addressing.
// Latency: control inputs sampled on a rising edge, new pc/running/done visible after that edge.
// Backpressure: stall holds pc, FSM and return stack; no input-to-output combinational paths.
//
// Ports: clk/rst_n (async active-low), start, stall, halt, branch_en, abs_jump,
//        target[7:0] (signed jump value), call, ret -> pc[PW-1:0], running, done, ras_err.
// Optional feature macro: PC_RAS_EN builds the return-address stack (call/ret, ras_err).
// Without it, call/ret are ignored and ras_err is tied low.
module pc_unit #(
    parameter int PW         = 10,
    parameter int START_ADDR = 0,
    parameter int RAS_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    input  logic          halt,
    input  logic          branch_en,
    input  logic          abs_jump,
    input  logic [7:0]    target,
    input  logic          call,
    input  logic          ret,
    output logic [PW-1:0] pc,
    output logic          running,
    output logic          done,
    output logic          ras_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [PW-1:0] START_PC = PW'(START_ADDR);

    state_t        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic          running_q, running_d;
    logic          done_q, done_d;

    logic [PW-1:0] pc_inc;
    logic [PW-1:0] pc_jmp;

    // Absolute jumps zero-extend the 8-bit table value; relative jumps sign-extend it.
    // Both wrap silently modulo 2^PW.
    assign pc_inc = pc_q + PW'(1);
    assign pc_jmp = abs_jump ? PW'(target) : (pc_q + PW'($signed(target)));

`ifdef PC_RAS_EN
    localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = AW + 1;

    // Circular stack: ptr_q is the next write slot, cnt_q the number of live entries.
    // When full, a push overwrites the slot at ptr_q, which holds the oldest entry.
    logic [PW-1:0] ras_q [RAS_DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          do_push;
    logic [AW-1:0] ptr_dec;
    logic          stk_empty;
    logic          stk_full;

    assign ptr_dec   = ptr_q - AW'(1);
    assign stk_empty = (cnt_q == '0);
    assign stk_full  = (cnt_q == CW'(RAS_DEPTH));
    assign ras_err   = err_q;
`else
    assign ras_err   = 1'b0;
    wire   unused_ras_inputs = &{1'b0, call, ret};
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = 1'b0;
`ifdef PC_RAS_EN
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        do_push = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_HALT: begin
                // start restarts from START_ADDR with an empty stack; ras_err is kept
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = START_PC;
`ifdef PC_RAS_EN
                    ptr_d   = '0;
                    cnt_d   = '0;
`endif
                end
            end
            ST_RUN: begin
                if (stall) begin
                    // hold everything, halt included
                end else if (halt) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
`ifdef PC_RAS_EN
                end else if (ret) begin
                    // ret has priority over call when both are asserted
                    if (stk_empty) begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end else begin
                        pc_d  = ras_q[ptr_dec];
                        ptr_d = ptr_dec;
                        cnt_d = cnt_q - CW'(1);
                    end
                end else if (call) begin
                    do_push = 1'b1;
                    ptr_d   = ptr_q + AW'(1);
                    if (stk_full) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    pc_d = pc_jmp;
`endif
                end else if (branch_en) begin
                    pc_d = pc_jmp;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = START_PC;
            end
        endcase
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_PC;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef PC_RAS_EN
            ptr_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
`ifdef PC_RAS_EN
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

`ifdef PC_RAS_EN
    // Stack storage needs no reset: entries are only read after being pushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_q[ptr_q] <= pc_inc;
        end
    end
`endif

    assign pc      = pc_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios followed by randomized control traffic.
// Expected values come from a queue-based reference model of the sequencer rules.
// Inputs change on the falling edge; outputs are compared on the following falling edge.
module tb_pc_unit;

    localparam int PW    = 10;
    localparam int START = 0;
    localparam int DEPTH = 4;
    localparam int MODV  = 1 << PW;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          halt = 1'b0;
    logic          branch_en = 1'b0;
    logic          abs_jump = 1'b0;
    logic [7:0]    target = 8'd0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic [PW-1:0] pc;
    logic          running;
    logic          done;
    logic          ras_err;

    pc_unit #(
        .PW         (PW),
        .START_ADDR (START),
        .RAS_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .halt      (halt),
        .branch_en (branch_en),
        .abs_jump  (abs_jump),
        .target    (target),
        .call      (call),
        .ret       (ret),
        .pc        (pc),
        .running   (running),
        .done      (done),
        .ras_err   (ras_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: 0 = idle, 1 = run, 2 = halt
    int m_state;
    int m_pc;
    bit m_done;
    bit m_run;
    bit m_err;
    int stk[$];

    task automatic model_reset();
        m_state = 0;
        m_pc    = START;
        m_done  = 1'b0;
        m_run   = 1'b0;
        m_err   = 1'b0;
        stk.delete();
    endtask

    function automatic int wrap(input int v);
        return ((v % MODV) + MODV) % MODV;
    endfunction

    function automatic int jump_dest(input int cur, input bit ab, input logic [7:0] tg);
        if (ab) return int'(tg);
        return wrap(cur + int'($signed(tg)));
    endfunction

    task automatic model_step(input bit st, input bit sl, input bit ht, input bit br,
                              input bit ab, input logic [7:0] tg, input bit cl, input bit rt);
        m_done = 1'b0;
        if (m_state != 1) begin
            if (st) begin
                m_state = 1;
                m_pc    = START;
                stk.delete();
            end
        end else if (sl) begin
            // nothing moves
        end else if (ht) begin
            m_state = 2;
            m_done  = 1'b1;
        end else if (RAS_ON && rt) begin
            if (stk.size() == 0) begin
                m_pc  = wrap(m_pc + 1);
                m_err = 1'b1;
            end else begin
                m_pc = stk.pop_back();
            end
        end else if (RAS_ON && cl) begin
            stk.push_back(wrap(m_pc + 1));
            if (stk.size() > DEPTH) begin
                void'(stk.pop_front());
                m_err = 1'b1;
            end
            m_pc = jump_dest(m_pc, ab, tg);
        end else if (br) begin
            m_pc = jump_dest(m_pc, ab, tg);
        end else begin
            m_pc = wrap(m_pc + 1);
        end
        m_run = (m_state == 1);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, int'(pc), m_pc);
        chk({tag, ".running"}, int'(running), int'(m_run));
        chk({tag, ".done"}, int'(done), int'(m_done));
        chk({tag, ".ras_err"}, int'(ras_err), int'(m_err));
    endtask

    // Called on a falling edge: drive inputs, advance model, check after next rising edge.
    task automatic cyc(input bit st, input bit sl, input bit ht, input bit br, input bit ab,
                       input logic [7:0] tg, input bit cl, input bit rt, input string tag);
        start     = st;
        stall     = sl;
        halt      = ht;
        branch_en = br;
        abs_jump  = ab;
        target    = tg;
        call      = cl;
        ret       = rt;
        model_step(st, sl, ht, br, ab, tg, cl, rt);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, tag);
    endtask

    task automatic jmp(input bit ab, input logic [7:0] tg, input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, ab, tg, 1'b0, 1'b0, tag);
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // start, then free-running increments
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "start");
        for (int i = 0; i < 5; i++) idle("inc");

        // absolute and relative jumps, stall
        jmp(1'b1, 8'd8, "abs8");
        jmp(1'b0, 8'hFD, "rel_m3");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "stall1");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd77, 1'b0, 1'b0, "stall_halt");

        // wrap-around both directions
        jmp(1'b0, 8'hFC, "to1");
        jmp(1'b0, 8'hFD, "wrap_neg");
        idle("to1023");
        idle("wrap_pos");
        jmp(1'b1, 8'd255, "abs255");
        jmp(1'b0, 8'd127, "rel127");

        // halt / restart
        jmp(1'b1, 8'd7, "to7");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "halt");
        idle("halted");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd40, 1'b0, 1'b0, "halt_br");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "restart");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "start_in_run");

        // call / return
        jmp(1'b1, 8'd3, "to3");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd20, 1'b1, 1'b0, "call20");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, "ret");
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd10, 1'b1, 1'b0, "nest_call");
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, "nest_ret");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd60, 1'b1, 1'b1, "call_ret");

        // asynchronous reset in the middle of a call cycle
        start = 1'b0; stall = 1'b0; halt = 1'b0; branch_en = 1'b1;
        abs_jump = 1'b1; target = 8'd50; call = 1'b1; ret = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "start2");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 30,
                $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
                $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
